// File: rtl/fault_inject_mod.sv
// fault_inject_mod: squares b, divides the product by a (restoring shift-subtract)
// and injects a configurable single-bit fault into the product or the remainder.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   start, b, a                  operation request, operand, modulus
//   f_arm, f_loc, f_type,        one-cycle load of the armed fault register
//   f_tgt, f_persist             (type: 00 none, 01 SA0, 10 SA1, 11 flip)
//   busy, done                   operation in flight / one-cycle completion pulse
//   c, y, div_zero               product, remainder, modulus-was-zero flag
//   fault_cnt                    saturating count of operations with an applied fault
module fault_inject_mod #(
  parameter int unsigned BW = 4,
  parameter int unsigned AW = 8,
  localparam int unsigned CW = 2 * BW,
  localparam int unsigned LW = $clog2(CW)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [BW-1:0] b,
  input  logic [AW-1:0] a,
  input  logic          f_arm,
  input  logic [LW-1:0] f_loc,
  input  logic [1:0]    f_type,
  input  logic          f_tgt,
  input  logic          f_persist,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] c,
  output logic [AW-1:0] y,
  output logic          div_zero,
  output logic [7:0]    fault_cnt
);

  localparam int unsigned CNTW = $clog2(CW);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DIV, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_a, w_a_nxt;
  logic [BW-1:0]   r_b, w_b_nxt;
  logic [LW-1:0]   r_loc, w_loc_nxt;
  logic [1:0]      r_type, w_type_nxt;
  logic            r_tgt, w_tgt_nxt;
  logic            r_persist, w_persist_nxt;
  logic [LW-1:0]   r_arm_loc, w_arm_loc_nxt;
  logic [1:0]      r_arm_type, w_arm_type_nxt;
  logic            r_arm_tgt, w_arm_tgt_nxt;
  logic            r_arm_persist, w_arm_persist_nxt;
  logic [AW-1:0]   r_rem, w_rem_nxt;
  logic [CW-1:0]   r_sh, w_sh_nxt;
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;
  logic            w_busy_nxt, w_done_nxt, w_dz_nxt;
  logic [CW-1:0]   w_c_nxt;
  logic [AW-1:0]   w_y_nxt;
  logic [7:0]      w_fcnt_nxt;

  logic [CW-1:0]   w_prod, w_prod_f, w_cmask;
  logic [AW-1:0]   w_ymask, w_rem_f;
  logic [AW:0]     w_trial;
  logic            w_ge, w_a_zero, w_y_in_range, w_hit;

  // Datapath helpers: squared operand, fault masks, division trial step
  always_comb begin
    w_prod       = CW'(r_b) * CW'(r_b);
    w_cmask      = CW'(1) << r_loc;
    w_ymask      = AW'(1) << r_loc;
    w_y_in_range = (32'(r_loc) < AW);
    w_a_zero     = (r_a == '0);
    w_trial      = {r_rem, r_sh[CW-1]};
    w_ge         = (w_trial >= {1'b0, r_a});
    case (r_type)
      2'b01:   begin w_prod_f = w_prod & ~w_cmask; w_rem_f = r_rem & ~w_ymask; end
      2'b10:   begin w_prod_f = w_prod |  w_cmask; w_rem_f = r_rem |  w_ymask; end
      2'b11:   begin w_prod_f = w_prod ^  w_cmask; w_rem_f = r_rem ^  w_ymask; end
      default: begin w_prod_f = w_prod;            w_rem_f = r_rem;            end
    endcase
    // A remainder fault counts only if it lands inside y and y is actually computed
    w_hit = (r_type != 2'b00) && (!r_tgt || (w_y_in_range && !w_a_zero));
  end

  // Next-state and next-register values
  always_comb begin
    w_state_nxt       = r_state;
    w_a_nxt           = r_a;
    w_b_nxt           = r_b;
    w_loc_nxt         = r_loc;
    w_type_nxt        = r_type;
    w_tgt_nxt         = r_tgt;
    w_persist_nxt     = r_persist;
    w_arm_loc_nxt     = r_arm_loc;
    w_arm_type_nxt    = r_arm_type;
    w_arm_tgt_nxt     = r_arm_tgt;
    w_arm_persist_nxt = r_arm_persist;
    w_rem_nxt         = r_rem;
    w_sh_nxt          = r_sh;
    w_cnt_nxt         = r_cnt;
    w_busy_nxt        = busy;
    w_done_nxt        = 1'b0;
    w_c_nxt           = c;
    w_y_nxt           = y;
    w_dz_nxt          = div_zero;
    w_fcnt_nxt        = fault_cnt;

    if (f_arm) begin
      w_arm_loc_nxt     = f_loc;
      w_arm_type_nxt    = f_type;
      w_arm_tgt_nxt     = f_tgt;
      w_arm_persist_nxt = f_persist;
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          // Latch the previously armed config; a same-cycle f_arm only affects later ops
          w_a_nxt       = a;
          w_b_nxt       = b;
          w_loc_nxt     = r_arm_loc;
          w_type_nxt    = r_arm_type;
          w_tgt_nxt     = r_arm_tgt;
          w_persist_nxt = r_arm_persist;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = S_CALC;
        end
      end
      S_CALC: begin
        w_c_nxt     = r_tgt ? w_prod : w_prod_f;
        w_sh_nxt    = r_tgt ? w_prod : w_prod_f;
        w_rem_nxt   = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = w_a_zero ? S_DONE : S_DIV;
      end
      S_DIV: begin
        w_rem_nxt = w_ge ? AW'(w_trial - {1'b0, r_a}) : AW'(w_trial);
        w_sh_nxt  = {r_sh[CW-2:0], 1'b0};
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CNTW'(CW - 1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_dz_nxt    = w_a_zero;
        if (w_a_zero)                  w_y_nxt = '0;
        else if (r_tgt && w_y_in_range) w_y_nxt = w_rem_f;
        else                           w_y_nxt = r_rem;
        if (w_hit && (fault_cnt != 8'hFF)) w_fcnt_nxt = fault_cnt + 8'd1;
        // One-shot auto-disarm, unless a new config is being armed this cycle
        if (!r_persist && !f_arm) w_arm_type_nxt = 2'b00;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_a           <= '0;
      r_b           <= '0;
      r_loc         <= '0;
      r_type        <= 2'b00;
      r_tgt         <= 1'b0;
      r_persist     <= 1'b0;
      r_arm_loc     <= '0;
      r_arm_type    <= 2'b00;
      r_arm_tgt     <= 1'b0;
      r_arm_persist <= 1'b0;
      r_rem         <= '0;
      r_sh          <= '0;
      r_cnt         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      c             <= '0;
      y             <= '0;
      div_zero      <= 1'b0;
      fault_cnt     <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_a           <= w_a_nxt;
      r_b           <= w_b_nxt;
      r_loc         <= w_loc_nxt;
      r_type        <= w_type_nxt;
      r_tgt         <= w_tgt_nxt;
      r_persist     <= w_persist_nxt;
      r_arm_loc     <= w_arm_loc_nxt;
      r_arm_type    <= w_arm_type_nxt;
      r_arm_tgt     <= w_arm_tgt_nxt;
      r_arm_persist <= w_arm_persist_nxt;
      r_rem         <= w_rem_nxt;
      r_sh          <= w_sh_nxt;
      r_cnt         <= w_cnt_nxt;
      busy          <= w_busy_nxt;
      done          <= w_done_nxt;
      c             <= w_c_nxt;
      y             <= w_y_nxt;
      div_zero      <= w_dz_nxt;
      fault_cnt     <= w_fcnt_nxt;
    end
  end

endmodule

// File: tb/tb_fault_inject_mod.sv
// Directed self-checking bench for fault_inject_mod (BW=4/AW=8, plus BW=8/AW=8
// instance so an out-of-range remainder fault location is representable).
module tb_fault_inject_mod;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, f_arm, f_tgt, f_persist;
  logic [3:0] b;
  logic [7:0] a;
  logic [2:0] f_loc;
  logic [1:0] f_type;
  logic       busy, done, div_zero;
  logic [7:0] c, y, fault_cnt;

  logic        start2, f_arm2, f_tgt2, f_persist2;
  logic [7:0]  b2, a2;
  logic [3:0]  f_loc2;
  logic [1:0]  f_type2;
  logic        busy2, done2, div_zero2;
  logic [15:0] c2;
  logic [7:0]  y2, fault_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fault_inject_mod #(.BW(4), .AW(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .b(b), .a(a),
    .f_arm(f_arm), .f_loc(f_loc), .f_type(f_type), .f_tgt(f_tgt), .f_persist(f_persist),
    .busy(busy), .done(done), .c(c), .y(y), .div_zero(div_zero), .fault_cnt(fault_cnt)
  );

  fault_inject_mod #(.BW(8), .AW(8)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .b(b2), .a(a2),
    .f_arm(f_arm2), .f_loc(f_loc2), .f_type(f_type2), .f_tgt(f_tgt2), .f_persist(f_persist2),
    .busy(busy2), .done(done2), .c(c2), .y(y2), .div_zero(div_zero2), .fault_cnt(fault_cnt2)
  );

  task automatic arm(input logic [2:0] loc, input logic [1:0] typ, input logic tgt, input logic per);
    @(negedge clk); f_arm = 1'b1; f_loc = loc; f_type = typ; f_tgt = tgt; f_persist = per;
    @(negedge clk); f_arm = 1'b0;
  endtask

  // Issue one operation; lat = number of edges after the accept edge until done (999 = timeout)
  task automatic do_op(input logic [3:0] ib, input logic [7:0] ia, output int lat);
    @(negedge clk); b = ib; a = ia; start = 1'b1;
    @(negedge clk); start = 1'b0; lat = 999;
    for (int n = 1; n <= 40 && lat == 999; n++) begin
      @(negedge clk);
      if (done === 1'b1) lat = n;
    end
  endtask

  task automatic arm2(input logic [3:0] loc, input logic [1:0] typ, input logic tgt, input logic per);
    @(negedge clk); f_arm2 = 1'b1; f_loc2 = loc; f_type2 = typ; f_tgt2 = tgt; f_persist2 = per;
    @(negedge clk); f_arm2 = 1'b0;
  endtask

  task automatic do_op2(input logic [7:0] ib, input logic [7:0] ia, output int lat);
    @(negedge clk); b2 = ib; a2 = ia; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0; lat = 999;
    for (int n = 1; n <= 60 && lat == 999; n++) begin
      @(negedge clk);
      if (done2 === 1'b1) lat = n;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b want 0", done); end
    n_checks++; if (c !== 8'd0) begin n_fail++; $display("FAIL rst_c: got %0d want 0", c); end
    n_checks++; if (y !== 8'd0) begin n_fail++; $display("FAIL rst_y: got %0d want 0", y); end
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL rst_dz: got %0b want 0", div_zero); end
    n_checks++; if (fault_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", fault_cnt); end
    reset_n = 1'b1;
  endtask

  task automatic test_no_fault();
    int lat;
    do_op(4'd13, 8'd10, lat);
    n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL nf_lat: got %0d want 10", lat); end
    n_checks++; if (c !== 8'd169) begin n_fail++; $display("FAIL nf_c: got %0d want 169", c); end
    n_checks++; if (y !== 8'd9) begin n_fail++; $display("FAIL nf_y: got %0d want 9", y); end
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL nf_dz: got %0b want 0", div_zero); end
    n_checks++; if (fault_cnt !== 8'd0) begin n_fail++; $display("FAIL nf_cnt: got %0d want 0", fault_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nf_busy: got %0b want 0", busy); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL nf_pulse: got %0b want 0", done); end
    n_checks++; if (y !== 8'd9) begin n_fail++; $display("FAIL nf_hold: got %0d want 9", y); end
  endtask

  task automatic test_sa0_persist();
    int lat;
    arm(3'd0, 2'b01, 1'b0, 1'b1);
    do_op(4'd13, 8'd10, lat);
    n_checks++; if (c !== 8'd168) begin n_fail++; $display("FAIL sa0_c1: got %0d want 168", c); end
    n_checks++; if (y !== 8'd8) begin n_fail++; $display("FAIL sa0_y1: got %0d want 8", y); end
    n_checks++; if (fault_cnt !== 8'd1) begin n_fail++; $display("FAIL sa0_cnt1: got %0d want 1", fault_cnt); end
    do_op(4'd13, 8'd10, lat);
    n_checks++; if (c !== 8'd168) begin n_fail++; $display("FAIL sa0_c2: got %0d want 168", c); end
    n_checks++; if (y !== 8'd8) begin n_fail++; $display("FAIL sa0_y2: got %0d want 8", y); end
    n_checks++; if (fault_cnt !== 8'd2) begin n_fail++; $display("FAIL sa0_cnt2: got %0d want 2", fault_cnt); end
  endtask

  task automatic test_flip_oneshot();
    int lat;
    arm(3'd7, 2'b11, 1'b0, 1'b0);
    do_op(4'd3, 8'd5, lat);
    n_checks++; if (c !== 8'd137) begin n_fail++; $display("FAIL flip_c1: got %0d want 137", c); end
    n_checks++; if (y !== 8'd2) begin n_fail++; $display("FAIL flip_y1: got %0d want 2", y); end
    do_op(4'd3, 8'd5, lat);
    n_checks++; if (c !== 8'd9) begin n_fail++; $display("FAIL flip_c2: got %0d want 9", c); end
    n_checks++; if (y !== 8'd4) begin n_fail++; $display("FAIL flip_y2: got %0d want 4", y); end
    n_checks++; if (fault_cnt !== 8'd3) begin n_fail++; $display("FAIL flip_cnt: got %0d want 3", fault_cnt); end
  endtask

  task automatic test_sa1_remainder();
    int lat;
    arm(3'd2, 2'b10, 1'b1, 1'b1);
    do_op(4'd13, 8'd10, lat);
    n_checks++; if (c !== 8'd169) begin n_fail++; $display("FAIL sa1y_c: got %0d want 169", c); end
    n_checks++; if (y !== 8'd13) begin n_fail++; $display("FAIL sa1y_y: got %0d want 13", y); end
    n_checks++; if (fault_cnt !== 8'd4) begin n_fail++; $display("FAIL sa1y_cnt: got %0d want 4", fault_cnt); end
    arm(3'd0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_div_zero();
    int lat;
    do_op(4'd13, 8'd0, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL dz_lat: got %0d want 2", lat); end
    n_checks++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %0b want 1", div_zero); end
    n_checks++; if (y !== 8'd0) begin n_fail++; $display("FAIL dz_y: got %0d want 0", y); end
    n_checks++; if (c !== 8'd169) begin n_fail++; $display("FAIL dz_c: got %0d want 169", c); end
    // Remainder fault with a==0: not applied, not counted
    arm(3'd3, 2'b10, 1'b1, 1'b0);
    do_op(4'd13, 8'd0, lat);
    n_checks++; if (y !== 8'd0) begin n_fail++; $display("FAIL dzf_y: got %0d want 0", y); end
    n_checks++; if (fault_cnt !== 8'd4) begin n_fail++; $display("FAIL dzf_cnt: got %0d want 4", fault_cnt); end
    // Product fault with a==0 still applies and counts
    arm(3'd1, 2'b10, 1'b0, 1'b0);
    do_op(4'd13, 8'd0, lat);
    n_checks++; if (c !== 8'd171) begin n_fail++; $display("FAIL dzp_c: got %0d want 171", c); end
    n_checks++; if (fault_cnt !== 8'd5) begin n_fail++; $display("FAIL dzp_cnt: got %0d want 5", fault_cnt); end
    n_checks++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL dzp_flag: got %0b want 1", div_zero); end
  endtask

  task automatic test_arm_during_start();
    int lat;
    arm(3'd0, 2'b11, 1'b0, 1'b1);
    @(negedge clk); b = 4'd13; a = 8'd10; start = 1'b1;
    f_arm = 1'b1; f_loc = 3'd0; f_type = 2'b00; f_tgt = 1'b0; f_persist = 1'b0;
    @(negedge clk); start = 1'b0; f_arm = 1'b0; lat = 999;
    for (int n = 1; n <= 40 && lat == 999; n++) begin
      @(negedge clk);
      if (done === 1'b1) lat = n;
    end
    n_checks++; if (c !== 8'd168) begin n_fail++; $display("FAIL ads_c: got %0d want 168", c); end
    n_checks++; if (y !== 8'd8) begin n_fail++; $display("FAIL ads_y: got %0d want 8", y); end
    n_checks++; if (fault_cnt !== 8'd6) begin n_fail++; $display("FAIL ads_cnt: got %0d want 6", fault_cnt); end
    do_op(4'd13, 8'd10, lat);
    n_checks++; if (c !== 8'd169) begin n_fail++; $display("FAIL ads_next_c: got %0d want 169", c); end
    n_checks++; if (fault_cnt !== 8'd6) begin n_fail++; $display("FAIL ads_next_cnt: got %0d want 6", fault_cnt); end
  endtask

  task automatic test_oneshot_rearm();
    int lat;
    arm(3'd0, 2'b11, 1'b0, 1'b0);
    @(negedge clk); b = 4'd13; a = 8'd10; start = 1'b1;
    @(negedge clk); start = 1'b0; lat = 999;
    for (int n = 1; n <= 40 && lat == 999; n++) begin
      @(negedge clk);
      if (n == 9) begin f_arm = 1'b1; f_loc = 3'd0; f_type = 2'b10; f_tgt = 1'b0; f_persist = 1'b0; end
      if (done === 1'b1) begin lat = n; f_arm = 1'b0; end
    end
    f_arm = 1'b0;
    n_checks++; if (c !== 8'd168) begin n_fail++; $display("FAIL rearm_c1: got %0d want 168", c); end
    n_checks++; if (fault_cnt !== 8'd7) begin n_fail++; $display("FAIL rearm_cnt1: got %0d want 7", fault_cnt); end
    // SA1 on an already-set bit: value unchanged but still counted
    do_op(4'd13, 8'd10, lat);
    n_checks++; if (c !== 8'd169) begin n_fail++; $display("FAIL rearm_c2: got %0d want 169", c); end
    n_checks++; if (fault_cnt !== 8'd8) begin n_fail++; $display("FAIL rearm_cnt2: got %0d want 8", fault_cnt); end
    do_op(4'd13, 8'd10, lat);
    n_checks++; if (fault_cnt !== 8'd8) begin n_fail++; $display("FAIL rearm_cnt3: got %0d want 8", fault_cnt); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk); b = 4'd13; a = 8'd10; start = 1'b1;
    @(negedge clk); start = 1'b0; lat = 999;
    for (int n = 1; n <= 40 && lat == 999; n++) begin
      @(negedge clk);
      if (n == 1) begin
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL btb_busy: got %0b want 1", busy); end
      end
      if (n == 2) begin start = 1'b1; b = 4'd3; a = 8'd5; end
      if (n == 3) start = 1'b0;
      if (done === 1'b1) lat = n;
    end
    start = 1'b0;
    n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL btb_lat: got %0d want 10", lat); end
    n_checks++; if (c !== 8'd169) begin n_fail++; $display("FAIL btb_c: got %0d want 169", c); end
    n_checks++; if (y !== 8'd9) begin n_fail++; $display("FAIL btb_y: got %0d want 9", y); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL btb_idle: got %0b want 0", busy); end
  endtask

  task automatic test_mid_reset();
    int lat;
    bit saw_done;
    @(negedge clk); b = 4'd13; a = 8'd10; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mr_busy: got %0b want 0", busy); end
    n_checks++; if (c !== 8'd0) begin n_fail++; $display("FAIL mr_c: got %0d want 0", c); end
    n_checks++; if (fault_cnt !== 8'd0) begin n_fail++; $display("FAIL mr_cnt: got %0d want 0", fault_cnt); end
    saw_done = 1'b0;
    repeat (2) begin @(negedge clk); if (done === 1'b1) saw_done = 1'b1; end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL mr_nodone: got %0b want 0", saw_done); end
    reset_n = 1'b1; b = 4'd3; a = 8'd5; start = 1'b1;
    @(negedge clk); start = 1'b0; lat = 999;
    for (int n = 1; n <= 40 && lat == 999; n++) begin
      @(negedge clk);
      if (done === 1'b1) lat = n;
    end
    n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL mr_lat: got %0d want 10", lat); end
    n_checks++; if (c !== 8'd9) begin n_fail++; $display("FAIL mr_c2: got %0d want 9", c); end
    n_checks++; if (y !== 8'd4) begin n_fail++; $display("FAIL mr_y2: got %0d want 4", y); end
  endtask

  task automatic test_loc_range();
    int lat;
    arm2(4'd9, 2'b10, 1'b1, 1'b1);
    do_op2(8'd13, 8'd10, lat);
    n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL lr_lat: got %0d want 18", lat); end
    n_checks++; if (c2 !== 16'd169) begin n_fail++; $display("FAIL lr_c: got %0d want 169", c2); end
    n_checks++; if (y2 !== 8'd9) begin n_fail++; $display("FAIL lr_y: got %0d want 9", y2); end
    n_checks++; if (fault_cnt2 !== 8'd0) begin n_fail++; $display("FAIL lr_cnt: got %0d want 0", fault_cnt2); end
    arm2(4'd3, 2'b10, 1'b1, 1'b1);
    do_op2(8'd13, 8'd10, lat);
    n_checks++; if (y2 !== 8'd9) begin n_fail++; $display("FAIL lr_y_in: got %0d want 9", y2); end
    n_checks++; if (fault_cnt2 !== 8'd1) begin n_fail++; $display("FAIL lr_cnt_in: got %0d want 1", fault_cnt2); end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; b = '0; a = '0;
    f_arm = 1'b0; f_loc = '0; f_type = 2'b00; f_tgt = 1'b0; f_persist = 1'b0;
    start2 = 1'b0; b2 = '0; a2 = '0;
    f_arm2 = 1'b0; f_loc2 = '0; f_type2 = 2'b00; f_tgt2 = 1'b0; f_persist2 = 1'b0;
    test_reset();
    test_no_fault();
    test_sa0_persist();
    test_flip_oneshot();
    test_sa1_remainder();
    test_div_zero();
    test_arm_during_start();
    test_oneshot_rearm();
    test_back_to_back();
    test_mid_reset();
    test_loc_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
